// File: rtl/mm2s_chk_pkg.sv
// ---------------------------------------------------------------------------
// mm2s_chk_pkg
// Shared definitions for the MM2S stream data checker:
//   - state_e    : checker state encoding (IDLE / RUN / FIN)
//   - LFSR_SEED  : seed loaded into the back-pressure LFSR on reset or Valid
//   - LFSR_TAPS  : Galois tap mask for a maximal-length 16-bit LFSR
//                  (x^16 + x^14 + x^13 + x^11 + 1, right-shifting form)
//   - ERR_W_DEF  : default error-counter width; the counter saturates at
//                  all ones of whatever ERR_W the top is built with
// ---------------------------------------------------------------------------
package mm2s_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned ERR_W_DEF = 16;

endpackage : mm2s_chk_pkg

// File: rtl/mm2s_data_checker_lfsr16_gen.sv
// ---------------------------------------------------------------------------
// lfsr16_gen
// 16-bit maximal-length Galois LFSR that advances every clock. Its low bit is
// used as a pseudo-random ready qualifier to stall the DMA stream about half
// of the time. Only instantiated when MM2S_CHK_BACKPRESSURE_EN is defined.
//
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset (loads the seed)
//   load    in  reload the seed (start of a new frame)
//   out_bit out current LFSR bit 0
// ---------------------------------------------------------------------------
module lfsr16_gen
  import mm2s_chk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic out_bit
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
    if (load) begin
      lfsr_d = LFSR_SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out_bit = lfsr_q[0];

endmodule : lfsr16_gen

// File: rtl/mm2s_data_checker.sv
// ---------------------------------------------------------------------------
// mm2s_data_checker
// AXI-Stream sink at the end of the DMA MM2S path. A Valid pulse arms it for
// one frame of Length beats; each accepted beat must carry tdata equal to the
// beat index (mod 2^DW) with all tkeep bits set, and tlast must appear on the
// final beat only. Status (pass, sticky error flags, saturating bad-beat
// count, beat count) stays visible until the next Valid.
//
// Optional build macro: MM2S_CHK_BACKPRESSURE_EN -- when defined, tready in
// RUN is gated by a free-running LFSR to exercise DMA stall handling.
//
// Ports:
//   axis_clk       in   clock
//   axis_reset     in   synchronous active-high reset
//   Length         in   expected beats per frame, sampled on Valid
//   Valid          in   start pulse; arms the checker (aborts a running frame)
//   s_axis_tdata   in   stream data
//   s_axis_tkeep   in   byte enables, must be all ones
//   s_axis_tvalid  in   stream valid
//   s_axis_tlast   in   stream end of frame
//   s_axis_tready  out  stream ready (RUN only)
//   busy           out  high while in RUN
//   done           out  one-cycle pulse when the frame completes
//   pass           out  frame was error-free, held from done until next Valid
//   err_data       out  sticky data / tkeep mismatch
//   err_last       out  sticky tlast misplacement
//   err_count      out  saturating count of bad beats
//   beat_cnt       out  beats accepted in the current frame
// ---------------------------------------------------------------------------
module mm2s_data_checker
  import mm2s_chk_pkg::*;
#(
  parameter int DW    = 8,
  parameter int LEN_W = 26,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic              axis_clk,
  input  logic              axis_reset,
  input  logic [LEN_W-1:0]  Length,
  input  logic              Valid,
  input  logic [DW-1:0]     s_axis_tdata,
  input  logic [DW/8-1:0]   s_axis_tkeep,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              err_data,
  output logic              err_last,
  output logic [ERR_W-1:0]  err_count,
  output logic [LEN_W-1:0]  beat_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               err_data_q, err_data_d;
  logic               err_last_q, err_last_d;
  logic               pass_q, pass_d;

  logic               run;
  logic               accept;
  logic               is_final;
  logic               data_bad;
  logic               last_bad;
  logic [DW-1:0]      expected;

  assign run = (state_q == RUN);

`ifdef MM2S_CHK_BACKPRESSURE_EN
  logic lfsr_bit;

  // Reseeding on Valid makes the stall pattern repeat identically per frame.
  lfsr16_gen u_lfsr (
    .clk     (axis_clk),
    .rst     (axis_reset),
    .load    (Valid),
    .out_bit (lfsr_bit)
  );

  assign s_axis_tready = run && lfsr_bit;
`else
  assign s_axis_tready = run;
`endif

  assign accept = s_axis_tvalid && s_axis_tready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    err_count_d = err_count_q;
    err_data_d  = err_data_q;
    err_last_d  = err_last_q;
    pass_d      = pass_q;

    // Expected pattern is the pre-increment beat index truncated to DW bits,
    // so it wraps every 2^DW beats.
    expected = DW'(beat_cnt_q);
    is_final = (beat_cnt_q == len_q - LEN_W'(1));
    data_bad = (s_axis_tdata != expected) || (s_axis_tkeep != '1);
    last_bad = is_final ? !s_axis_tlast : s_axis_tlast;

    if (Valid) begin
      // Valid re-arms from any state and wins over a beat in the same cycle;
      // that beat is dropped without being checked.
      len_d       = Length;
      beat_cnt_d  = '0;
      err_count_d = '0;
      err_data_d  = 1'b0;
      err_last_d  = 1'b0;
      // An empty frame goes straight to FIN and is trivially clean.
      pass_d      = (Length == '0);
      state_d     = (Length == '0) ? FIN : RUN;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (accept) begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
            if (data_bad) err_data_d = 1'b1;
            if (last_bad) err_last_d = 1'b1;
            // One increment per bad beat, even if it is bad in both ways.
            if ((data_bad || last_bad) && (err_count_q != ERR_MAX)) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            // The final beat ends the frame whatever tlast says; an early
            // tlast ends it too and later beats are never accepted.
            if (is_final || s_axis_tlast) begin
              state_d = FIN;
              // pass is settled on entry to FIN so it is valid alongside done.
              pass_d  = !(err_data_d || err_last_d);
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      err_count_q <= '0;
      err_data_q  <= 1'b0;
      err_last_q  <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      err_count_q <= err_count_d;
      err_data_q  <= err_data_d;
      err_last_q  <= err_last_d;
      pass_q      <= pass_d;
    end
  end

  assign busy      = run;
  assign done      = (state_q == FIN);
  assign pass      = pass_q;
  assign err_data  = err_data_q;
  assign err_last  = err_last_q;
  assign err_count = err_count_q;
  assign beat_cnt  = beat_cnt_q;

endmodule : mm2s_data_checker

// File: tb/tb_mm2s_data_checker.sv
// ---------------------------------------------------------------------------
// tb_mm2s_data_checker
// Directed frames against mm2s_data_checker. A frame-level model derives the
// expected outcome of each frame from its beat list; a per-cycle monitor
// compares done/busy/tready/beat_cnt/pass (and the error status at done)
// against that model, and literal checks after each frame pin the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mm2s_data_checker;

  localparam int DW    = 8;
  localparam int LEN_W = 26;
  localparam int ERR_W = 16;

  logic              axis_clk = 1'b0;
  logic              axis_reset;
  logic [LEN_W-1:0]  Length;
  logic              Valid;
  logic [DW-1:0]     s_axis_tdata;
  logic [DW/8-1:0]   s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              busy;
  logic              done;
  logic              pass;
  logic              err_data;
  logic              err_last;
  logic [ERR_W-1:0]  err_count;
  logic [LEN_W-1:0]  beat_cnt;

  always #5 axis_clk = ~axis_clk;

  mm2s_data_checker #(.DW(DW), .LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
    .axis_clk      (axis_clk),
    .axis_reset    (axis_reset),
    .Length        (Length),
    .Valid         (Valid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_data      (err_data),
    .err_last      (err_last),
    .err_count     (err_count),
    .beat_cnt      (beat_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Beat list of the frame being sent.
  logic [DW-1:0]   q_data[$];
  bit              q_last[$];
  logic [DW/8-1:0] q_keep[$];

  // Frame-level model results.
  int m_n;
  bit m_ed, m_el, m_pass;
  int m_cnt;

  // Tracking state used by the monitor.
  int m_acc         = 0;
  bit m_busy        = 0;
  int exp_done_cyc  = -1;
  bit exp_pass_hold = 0;
  bit chk_en        = 0;
  int rdy_hi        = 0;
  int rdy_lo        = 0;

  function automatic void model_frame(input int len);
    m_n = 0; m_ed = 0; m_el = 0; m_cnt = 0;
    for (int i = 0; i < len; i++) begin
      bit bd, bl, fin;
      fin = (i == len - 1);
      bd  = (int'(q_data[i]) != (i % 256)) || (q_keep[i] != 1'b1);
      bl  = fin ? !q_last[i] : q_last[i];
      if (bd) m_ed = 1;
      if (bl) m_el = 1;
      if ((bd || bl) && m_cnt < 65535) m_cnt++;
      m_n = i + 1;
      if (fin || q_last[i]) break;
    end
    m_pass = !(m_ed || m_el);
  endfunction

  task automatic build_good(input int len);
    q_data.delete(); q_last.delete(); q_keep.delete();
    for (int i = 0; i < len; i++) begin
      q_data.push_back(DW'(i));
      q_last.push_back(i == len - 1);
      q_keep.push_back(1'b1);
    end
  endtask

  // Called at posedge+1. Pulses Valid now; streams beats until the model's
  // end of frame, or stops at beat abort_at leaving that beat on the bus.
  task automatic run_frame(input int len, input int abort_at);
    int   i;
    int   budget;
    logic rdy;
    model_frame(len);
    Valid  = 1'b1;
    Length = LEN_W'(len);
    if (len == 0) exp_done_cyc = cyc + 1;
    @(posedge axis_clk); #1;
    Valid         = 1'b0;
    m_acc         = 0;
    exp_pass_hold = 0;
    m_busy        = (len != 0);
    i = 0; budget = 0;
    while (i < m_n && i != abort_at) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = q_data[i];
      s_axis_tlast  = q_last[i];
      s_axis_tkeep  = q_keep[i];
      @(negedge axis_clk);
      rdy = s_axis_tready;
      @(posedge axis_clk); #1;
      if (rdy === 1'b1) begin
        m_acc++;
        if (i == m_n - 1) begin
          exp_done_cyc = cyc;
          m_busy       = 0;
        end
        i++;
        budget = 0;
      end else begin
        budget++;
        if (budget > 200) begin
          check("handshake_timeout", 0, 1);
          break;
        end
      end
    end
    if (abort_at >= 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = q_data[abort_at];
      s_axis_tlast  = q_last[abort_at];
      s_axis_tkeep  = q_keep[abort_at];
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge axis_clk);
    #1;
  endtask

  // Per-cycle monitor.
  always @(negedge axis_clk) begin
    if (chk_en) begin
      check("done", done, cyc == exp_done_cyc);
      check("busy", busy, m_busy);
`ifdef MM2S_CHK_BACKPRESSURE_EN
      if (!m_busy) check("tready_idle", s_axis_tready, 0);
      else if (s_axis_tready === 1'b1) rdy_hi++;
      else rdy_lo++;
`else
      check("tready", s_axis_tready, m_busy);
`endif
      check("beat_cnt", beat_cnt, m_acc);
      if (cyc == exp_done_cyc) begin
        exp_pass_hold = m_pass;
        check("err_data_at_done", err_data, m_ed);
        check("err_last_at_done", err_last, m_el);
        check("err_count_at_done", err_count, m_cnt);
      end
      check("pass", pass, exp_pass_hold);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_reset    = 1'b1;
    Valid         = 1'b0;
    Length        = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = '1;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    check("rst_tready",    s_axis_tready, 0);
    check("rst_busy",      busy, 0);
    check("rst_done",      done, 0);
    check("rst_pass",      pass, 0);
    check("rst_err_data",  err_data, 0);
    check("rst_err_last",  err_last, 0);
    check("rst_err_count", err_count, 0);
    check("rst_beat_cnt",  beat_cnt, 0);

    // Valid together with reset: reset wins, nothing is armed.
    @(posedge axis_clk); #1;
    axis_reset = 1'b1; Valid = 1'b1; Length = LEN_W'(5);
    @(posedge axis_clk); #1;
    axis_reset = 1'b0; Valid = 1'b0;
    @(negedge axis_clk);
    check("rstvalid_busy", busy, 0);
    check("rstvalid_done", done, 0);
    @(posedge axis_clk); #1;
    chk_en = 1;

    // Clean 16-beat frame.
    build_good(16);
    run_frame(16, -1);
    idle_cycles(3);
    check("f16_beat_cnt", beat_cnt, 16);
    check("f16_pass", pass, 1);
    check("f16_err_count", err_count, 0);

    // Bad data on beat 3.
    build_good(8);
    q_data[3] = 8'hFF;
    run_frame(8, -1);
    idle_cycles(3);
    check("data_err_flag", err_data, 1);
    check("data_err_count", err_count, 1);
    check("data_err_pass", pass, 0);
    check("data_err_beats", beat_cnt, 8);

    // Early tlast on beat 5.
    build_good(8);
    q_last[5] = 1'b1;
    run_frame(8, -1);
    idle_cycles(3);
    check("early_model_n", m_n, 6);
    check("early_beat_cnt", beat_cnt, 6);
    check("early_err_last", err_last, 1);
    check("early_pass", pass, 0);

    // Pattern wrap over 300 beats.
    build_good(300);
    run_frame(300, -1);
    idle_cycles(3);
    check("wrap_pass", pass, 1);
    check("wrap_beat_cnt", beat_cnt, 300);

    // tkeep error on beat 2, then a beat with both bad data and early tlast.
    build_good(6);
    q_keep[2] = 1'b0;
    q_data[4] = 8'h55;
    q_last[4] = 1'b1;
    run_frame(6, -1);
    idle_cycles(3);
    check("dual_err_count", err_count, 2);
    check("dual_beat_cnt", beat_cnt, 5);
    check("dual_err_data", err_data, 1);
    check("dual_err_last", err_last, 1);

    // Missing tlast on the final beat still ends the frame.
    build_good(5);
    q_last[4] = 1'b0;
    run_frame(5, -1);
    idle_cycles(3);
    check("notlast_err_last", err_last, 1);
    check("notlast_beat_cnt", beat_cnt, 5);

    // Abort a 10-beat frame at beat 4 with a new 4-beat frame.
    build_good(10);
    run_frame(10, 4);
    build_good(4);
    run_frame(4, -1);
    idle_cycles(3);
    check("abort_beat_cnt", beat_cnt, 4);
    check("abort_pass", pass, 1);

    // Empty frame.
    build_good(0);
    run_frame(0, -1);
    idle_cycles(3);
    check("len0_pass", pass, 1);
    check("len0_beat_cnt", beat_cnt, 0);

`ifdef MM2S_CHK_BACKPRESSURE_EN
    rdy_hi = 0; rdy_lo = 0;
    build_good(64);
    run_frame(64, -1);
    idle_cycles(3);
    check("bp_stalled", rdy_lo > 0, 1);
    check("bp_ready", rdy_hi > 0, 1);
    check("bp_pass", pass, 1);
    check("bp_beat_cnt", beat_cnt, 64);
`endif

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mm2s_data_checker

// File: doc/mm2s_data_checker.md
Name: mm2s_data_checker

Overview:
- AXI-Stream slave at the receive end of the DMA read (MM2S) path; counterpart of the S2MM data generator.
- Consumes one frame of Length beats and checks that tdata follows the incrementing pattern (beat index mod 2^DW) and that tlast sits exactly on the final beat.
- Reports pass/fail status and error counters so the write-then-read DDR loopback can be self-checked in hardware.

Parameters:
- DW, 8, stream data width in bits (multiple of 8).
- LEN_W, 26, width of Length and of the beat counter.
- ERR_W, 16, width of the saturating error counter.

Ports:
- axis_clk  in  1  single clock for all logic.
- axis_reset  in  1  synchronous, active-high reset.
- Length  in  LEN_W  expected beats per frame; sampled on Valid.
- Valid  in  1  start pulse; arms the checker and clears status.
- s_axis_tdata  in  DW  stream data.
- s_axis_tkeep  in  DW/8  byte enables; must be all ones.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  stream end of frame.
- s_axis_tready  out  1  stream ready.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at frame end.
- pass  out  1  held high from done until the next Valid if the frame was error-free.
- err_data  out  1  sticky; set on a data or tkeep mismatch.
- err_last  out  1  sticky; set on a tlast misplacement.
- err_count  out  ERR_W  saturating count of bad beats.
- beat_cnt  out  LEN_W  beats accepted in the current frame.

Behaviour:
- Reset values: s_axis_tready=0, busy=0, done=0, pass=0, err_*=0, err_count=0, beat_cnt=0; state IDLE.
- States: IDLE, RUN, FIN.
- A beat is accepted when s_axis_tvalid && s_axis_tready.
- IDLE:
  - tready=0.
  - On Valid: latch Length, clear beat_cnt, err_*, err_count and pass.
  - Length==0 -> FIN; otherwise -> RUN.
- RUN:
  - tready=1, busy=1.
  - Per accepted beat: expected = beat_cnt[DW-1:0] zero-extended to DW bits.
  - Mismatch on tdata, or tkeep not all ones -> set err_data and increment err_count (saturating at all ones).
  - A beat may carry both a data error and a tlast error; err_count increments once for that beat.
  - beat_cnt increments per accepted beat; the compare uses the pre-increment value.
- Final beat (beat_cnt == Length_latched-1):
  - tlast=0 sets err_last.
  - The state goes to FIN regardless of tlast.
- Early tlast (tlast=1 on an earlier beat): set err_last, increment err_count, go to FIN; remaining beats are not accepted.
- FIN:
  - tready=0.
  - done=1 for exactly one cycle.
  - pass <= ~(err_data|err_last).
  - Next state IDLE.
- Valid while in RUN or FIN aborts the current frame: status is cleared, the new Length is latched, and the checker re-arms the same cycle.
  - No done is emitted for the aborted frame.
  - Valid has priority over a simultaneous accepted beat; that beat is discarded and not checked.
- Valid and axis_reset in the same cycle: reset wins.
- Latency: done is asserted 1 cycle after the final accepted beat; with Length==0, 1 cycle after Valid.
- beat_cnt holds its final value after done until the next Valid.
- tdata pattern wraps every 2^DW beats: beat 256 expects 0x00 when DW=8.

Optional Feature:
- Macro: MM2S_CHK_BACKPRESSURE_EN.
- Defined:
  - In RUN, s_axis_tready = run && lfsr_bit.
  - A 16-bit maximal LFSR (seed 16'hACE1 on reset or Valid) advances every cycle and deasserts ready roughly half the time.
  - This exercises DMA stall handling; the checking rules are unchanged.
- Undefined: tready is constantly 1 in RUN and no LFSR logic is built.

Decomposition:
- Shared package mm2s_chk_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, FIN=2'd2);
  - the LFSR seed and tap constants;
  - the ERR_W saturation helper constant.
- One sub-module, lfsr16_gen (clock, reset, load, out bit), instantiated only under MM2S_CHK_BACKPRESSURE_EN.

Test Plan:
- Length=16, stream 0x00..0x0F with tlast on beat 15 -> done after 1 cycle, pass=1, err_count=0, beat_cnt=16.
- Length=8, beat 3 data=0xFF -> err_data=1, err_count=1, pass=0, done after beat 7.
- Length=8, tlast on beat 5 -> err_last=1, FIN after beat 5, beat_cnt=6, pass=0.
- Length=300, DW=8 -> beat 256 expects 0x00 and beat 299 expects 0x2B; pass=1.
- Valid pulsed at beat 4 of a Length=10 frame, followed by a new Length=4 frame -> no done for the first frame; second frame passes, beat_cnt=4.
- Length=0 -> done one cycle after Valid, pass=1, tready never asserted; with MM2S_CHK_BACKPRESSURE_EN on a Length=64 frame -> tready toggles and pass=1.
